// File: rtl/ram_dma.sv
// Block-transfer initiator for the 1024 x 20-bit data RAM: copies a run of words
// (read, wait, write per word) or fills a region with a constant, owning the RAM port while busy.
module ram_dma #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W:0]   i_len,
  input  logic [DATA_W-1:0] i_fill_val,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_write,
  output logic              o_str,
  output logic              o_ld,
  input  logic [DATA_W-1:0] i_read
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  logic                r_mode,  w_mode_nxt;
  logic [ADDR_W-1:0]   r_src,   w_src_nxt;
  logic [ADDR_W-1:0]   r_dst,   w_dst_nxt;
  logic [ADDR_W:0]     r_len,   w_len_nxt;
  logic [DATA_W-1:0]   r_fill,  w_fill_nxt;
  logic [ADDR_W:0]     r_cnt,   w_cnt_nxt;
  logic [DATA_W-1:0]   r_buf,   w_buf_nxt;
  logic [ADDR_W-1:0]   w_idx;

  logic                r_busy,  w_busy_nxt;
  logic                r_done,  w_done_nxt;
  logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
  logic [DATA_W-1:0]   r_write, w_write_nxt;
  logic                r_str,   w_str_nxt;
  logic                r_ld,    w_ld_nxt;

  // State, latched command and word counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_src   <= {ADDR_W{1'b0}};
      r_dst   <= {ADDR_W{1'b0}};
      r_len   <= CNT_ZERO;
      r_fill  <= {DATA_W{1'b0}};
      r_cnt   <= CNT_ZERO;
      r_buf   <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_len   <= w_len_nxt;
      r_fill  <= w_fill_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Next-state logic; read data is captured on the edge closing the second held-address cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_fill_nxt  = r_fill;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_mode_nxt = i_mode;
          w_src_nxt  = i_src;
          w_dst_nxt  = i_dst;
          w_len_nxt  = i_len;
          w_fill_nxt = i_fill_val;
          w_cnt_nxt  = CNT_ZERO;
          if (i_len == CNT_ZERO) begin
            w_state_nxt = S_FIN;
          end else if (i_mode) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: w_state_nxt = S_WT;
      S_WT: begin
        w_buf_nxt   = i_read;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if ((r_cnt + CNT_ONE) == r_len) begin
          w_state_nxt = S_FIN;
        end else if (r_mode) begin
          w_state_nxt = S_WR;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_idx = w_cnt_nxt[ADDR_W-1:0];

  // Port values for the upcoming state, so the registered outputs line up with it.
  always_comb begin
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = {ADDR_W{1'b0}};
    w_write_nxt = {DATA_W{1'b0}};
    w_str_nxt   = 1'b0;
    w_ld_nxt    = 1'b0;
    case (w_state_nxt)
      S_RD, S_WT: begin
        w_addr_nxt = w_src_nxt + w_idx;
        w_ld_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_WR: begin
        w_addr_nxt  = w_dst_nxt + w_idx;
        w_write_nxt = w_mode_nxt ? w_fill_nxt : w_buf_nxt;
        w_str_nxt   = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      S_FIN:   w_done_nxt = 1'b1;
      default: w_done_nxt = 1'b0;
    endcase
  end

  // Output registers; reset clears str at once so no write lands on the following edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_write <= {DATA_W{1'b0}};
      r_str   <= 1'b0;
      r_ld    <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_addr  <= w_addr_nxt;
      r_write <= w_write_nxt;
      r_str   <= w_str_nxt;
      r_ld    <= w_ld_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_addr  = r_addr;
  assign o_write = r_write;
  assign o_str   = r_str;
  assign o_ld    = r_ld;

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma against a behavioural RAM with combinational read.
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  src = 10'd0;
  logic [9:0]  dst = 10'd0;
  logic [10:0] len = 11'd0;
  logic [19:0] fill_val = 20'd0;
  logic        busy, done, str, ld;
  logic [9:0]  addr;
  logic [19:0] wdata, rdata;

  logic [19:0] mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = 10'd0;
  logic [19:0] pl_data = 20'd0;

  int n_vec = 0;
  int n_err = 0;
  int done_cyc, done_cnt, str_cnt, ld_cnt, both_cnt, rd0_cnt;

  always #5 clk = ~clk;

  ram_dma dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_src(src), .i_dst(dst), .i_len(len), .i_fill_val(fill_val),
    .o_busy(busy), .o_done(done), .o_addr(addr), .o_write(wdata),
    .o_str(str), .o_ld(ld), .i_read(rdata)
  );

  // RAM model: bench preload port has priority, otherwise DUT stores.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (str) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];

  function automatic logic [19:0] pat(input logic [9:0] a);
    return {10'h2A5, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [19:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one command and observe maxc cycles; inj>0 pulses a second start with dst=200 in that cycle.
  task automatic run(input logic m, input logic [9:0] s, input logic [9:0] d,
                     input logic [10:0] l, input logic [19:0] f, input int maxc, input int inj);
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0; done_cnt = 0; str_cnt = 0; ld_cnt = 0; both_cnt = 0; rd0_cnt = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (str) str_cnt++;
      if (ld) ld_cnt++;
      if (str && ld) both_cnt++;
      if (ld && addr == 10'd0) rd0_cnt++;
      if (c == inj) begin
        start = 1'b1; dst = 10'd200;
      end else if (c == inj + 1) begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    for (int i = 0; i < 1024; i++) poke(10'(i), pat(10'(i)));
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_str", str, 1'b0);
    chk("rst_ld", ld, 1'b0);
    chk("rst_addr", addr, 10'd0);
    chk("rst_write", wdata, 20'd0);
    rst = 1'b0;

    // Copy four words 0..3 -> 100..103
    poke(10'd0, 20'd101); poke(10'd1, 20'd202); poke(10'd2, 20'd303); poke(10'd3, 20'd404);
    run(1'b0, 10'd0, 10'd100, 11'd4, 20'd0, 16, 0);
    chk("copy_m100", mem[100], 20'd101);
    chk("copy_m101", mem[101], 20'd202);
    chk("copy_m102", mem[102], 20'd303);
    chk("copy_m103", mem[103], 20'd404);
    chk("copy_m104", mem[104], pat(10'd104));
    chk("copy_done_cyc", done_cyc, 13);
    chk("copy_done_cnt", done_cnt, 1);
    chk("copy_str_cnt", str_cnt, 4);
    chk("copy_ld_cnt", ld_cnt, 8);
    chk("copy_str_ld", both_cnt, 0);
    chk("copy_idle", busy, 1'b0);

    // Fill three words at 500
    run(1'b1, 10'd0, 10'd500, 11'd3, 20'hABCDE, 8, 0);
    chk("fill_m500", mem[500], 20'hABCDE);
    chk("fill_m501", mem[501], 20'hABCDE);
    chk("fill_m502", mem[502], 20'hABCDE);
    chk("fill_m499", mem[499], pat(10'd499));
    chk("fill_m503", mem[503], pat(10'd503));
    chk("fill_done_cyc", done_cyc, 4);
    chk("fill_str_cnt", str_cnt, 3);
    chk("fill_ld_cnt", ld_cnt, 0);

    // Wrapping overlapped copy 1022.. -> 1021..
    poke(10'd1022, 20'd7); poke(10'd1023, 20'd8); poke(10'd0, 20'd9);
    run(1'b0, 10'd1022, 10'd1021, 11'd3, 20'd0, 13, 0);
    chk("wrap_m1021", mem[1021], 20'd7);
    chk("wrap_m1022", mem[1022], 20'd8);
    chk("wrap_m1023", mem[1023], 20'd9);
    chk("wrap_rd0", rd0_cnt, 2);
    chk("wrap_done_cyc", done_cyc, 10);

    // Zero length
    run(1'b0, 10'd0, 10'd0, 11'd0, 20'd0, 4, 0);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_str_cnt", str_cnt, 0);
    chk("zero_ld_cnt", ld_cnt, 0);
    chk("zero_m0", mem[0], 20'd9);

    // Second start during a copy must be ignored
    poke(10'd300, 20'd11); poke(10'd301, 20'd22); poke(10'd302, 20'd33);
    run(1'b0, 10'd300, 10'd310, 11'd3, 20'd0, 16, 4);
    chk("busy_m310", mem[310], 20'd11);
    chk("busy_m311", mem[311], 20'd22);
    chk("busy_m312", mem[312], 20'd33);
    chk("busy_m200", mem[200], pat(10'd200));
    chk("busy_done_cyc", done_cyc, 10);
    chk("busy_done_cnt", done_cnt, 1);
    chk("busy_str_cnt", str_cnt, 3);
    chk("busy_idle", busy, 1'b0);

    // Reset during the third write of a four-word fill at 10
    @(negedge clk);
    mode = 1'b1; dst = 10'd10; len = 11'd4; fill_val = 20'h12345; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_str_pre", str, 1'b1);
    chk("mid_addr_pre", addr, 10'd12);
    rst = 1'b1;
    #1;
    chk("mid_str", str, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_addr", addr, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_m10", mem[10], 20'h12345);
    chk("mid_m11", mem[11], 20'h12345);
    chk("mid_m12", mem[12], pat(10'd12));
    chk("mid_m13", mem[13], pat(10'd13));
    run(1'b1, 10'd0, 10'd20, 11'd2, 20'd5, 6, 0);
    chk("post_done_cyc", done_cyc, 3);
    chk("post_m20", mem[20], 20'd5);
    chk("post_m21", mem[21], 20'd5);
    chk("post_m22", mem[22], pat(10'd22));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-transfer initiator for the 1024 x 20-bit data RAM. On a start command it copies a run of words from a source region to a destination region, or fills a region with a constant, by driving the RAM's `addr`/`write`/`str`/`ld` port and sampling its `read` bus. It sits between the CPU control unit and the RAM port and owns that port while busy.

## Interface

Parameters:
- `ADDR_W`, 10, RAM address width (1024 words).
- `DATA_W`, 20, RAM word width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched on start.
- `src`  in  ADDR_W  copy source base address; latched on start.
- `dst`  in  ADDR_W  destination base address; latched on start.
- `len`  in  ADDR_W+1  word count, 0..1024; latched on start.
- `fill_val`  in  DATA_W  fill constant; latched on start.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse at transfer completion.
- `addr`  out  ADDR_W  RAM address.
- `write`  out  DATA_W  RAM write data.
- `str`  out  1  RAM store enable; RAM writes `write` to `addr` on the rising edge.
- `ld`  out  1  RAM load enable.
- `read`  in  DATA_W  RAM read data.

## Operation

- States: IDLE, RD, WT, WR, FIN.
- IDLE: `addr`=0, `write`=0, `str`=0, `ld`=0, `busy`=0, `done`=0.
- IDLE + `start`=1 latches `mode`, `src`, `dst`, `len`, and `fill_val`, and clears the word counter.
  - `len`=0 -> FIN.
  - copy -> RD.
  - fill -> WR.
- RD: `addr`=src+i, `ld`=1 -> WT.
- WT: holds `addr` and `ld`=1. On the closing edge, `read` is captured into an internal buffer -> WR.
  - Sampling at the end of the second held cycle is mandatory; this makes the block correct for both combinational and registered RAM reads.
- WR: `addr`=dst+i, `write`=buffer (copy) or `fill_val` (fill), `str`=1, `ld`=0.
  - Increment i.
  - If i+1 == len -> FIN; otherwise copy -> RD, fill -> WR.
- FIN: `done`=1, `busy`=0, RAM outputs as in IDLE -> IDLE.
- `busy`=1 in RD, WT, and WR only.
- `str` and `ld` are never high in the same cycle.
- Address arithmetic is modulo 2^ADDR_W: src+i and dst+i wrap from 1023 to 0.
- The counter is ADDR_W+1 bits so that `len`=1024 is representable.
- Overlapping regions are copied strictly in ascending order, one word at a time. Each read completes before the next write, so a forward overlap (dst > src) propagates already-written values. This is defined behaviour, not an error.
- `start` while not in IDLE is ignored; the latched parameters do not change.
- `start` held high through FIN starts a new transfer on the first IDLE cycle.

## Timing

- Reset: state = IDLE immediately (asynchronous). All outputs are 0, including `str`, so no write occurs on the next edge. A reset mid-transfer aborts; words already written remain in the RAM.
- `start` is sampled at edge 0.
- Copy of N words:
  - Cycles 1..3N are RD/WT/WR triplets; word k is written at the end of cycle 3k+3.
  - `done` is high in cycle 3N+1; IDLE resumes in cycle 3N+2.
- Fill of N words:
  - Cycles 1..N are WR; `done` is high in cycle N+1.
- `len`=0: `done` is high in cycle 1, with no `str` or `ld` activity.
- Throughput: copy is 3 cycles/word, fill is 1 cycle/word.

## Test plan

- **Copy:** preload RAM[0..3] = 101, 202, 303, 404; copy with src=0, dst=100, len=4.
  - RAM[100..103] = 101, 202, 303, 404.
  - `done` pulses exactly 13 cycles after the start edge.
  - `str` is high for exactly 4 cycles.
- **Fill:** mode=1, dst=500, len=3, fill_val=20'hABCDE.
  - RAM[500..502] = ABCDE.
  - RAM[499] and RAM[503] are unchanged.
  - `done` is high in cycle 4.
- **Wrap:** preload RAM[1022]=7, RAM[1023]=8, RAM[0]=9; copy src=1022, dst=1021, len=3.
  - RAM[1021..1023] = 7, 8, 9.
  - `addr` is observed to go 1023 -> 0.
- **Zero length:** `len`=0, mode=0.
  - `done` is high in cycle 1.
  - `str`=`ld`=0 throughout; the RAM is untouched.
- **Start while busy:** pulse `start` with different `dst` during a copy.
  - The first transfer completes unchanged.
  - `done` pulses only once.
  - The second command has no effect.
- **Reset mid-operation:** assert `rst` during the WR of word 2 of a 4-word fill at dst=10.
  - `str`, `busy`, and `addr` go to 0 immediately.
  - RAM[10..11] are written; RAM[12..13] are unchanged.
  - After release, a new start behaves normally.
